// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM read/write arbiter: sequencer states and port index.
package ram_arb_pkg;

    typedef enum logic {
        INIT = 1'b0,
        ARB  = 1'b1
    } state_t;

    typedef logic port_t;

    localparam port_t PORT0 = 1'b0;
    localparam port_t PORT1 = 1'b1;

    // Under contention the port that did not win last time goes next.
    function automatic port_t rr_pick(input port_t last);
        return (last == PORT1) ? PORT0 : PORT1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter; grants are combinational, the last winner is registered.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1,
    output logic last
);

    port_t last_q;
    port_t pick;

    assign pick = rr_pick(last_q);
    assign last = last_q;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (en) begin
            if (req0 && req1) begin
                gnt0 = (pick == PORT0);
                gnt1 = (pick == PORT1);
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    // Reset to port 1 so port 0 wins the first conflict.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= PORT1;
        end else if (gnt0) begin
            last_q <= PORT0;
        end else if (gnt1) begin
            last_q <= PORT1;
        end
    end

endmodule

// File: rtl/ram_rw_arbiter.sv
// Zero-fills a single-port RAM after reset/clear, then shares it between two
// requesters round-robin, returning read data with a registered valid strobe.
module ram_rw_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  init_done,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic                  arb_en;
    logic                  last;

    assign arb_en    = (state == ARB);
    assign init_done = (state == ARB);
    assign rdata     = ram_rdata;

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .reset (reset),
        .en    (arb_en),
        .req0  (req0),
        .req1  (req1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .last  (last)
    );

    // Sequencer: zero-fill walk, then arbitration; read strobes follow a granted read by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= INIT;
            init_cnt <= '0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    rvalid0 <= 1'b0;
                    rvalid1 <= 1'b0;
                    if (clr) begin
                        init_cnt <= '0;
                    end else if (init_cnt == LAST_ADDR) begin
                        init_cnt <= '0;
                        state    <= ARB;
                    end else begin
                        init_cnt <= init_cnt + 1'b1;
                    end
                end
                ARB: begin
                    rvalid0 <= gnt0 && !we0;
                    rvalid1 <= gnt1 && !we1;
                    if (clr) begin
                        init_cnt <= '0;
                        state    <= INIT;
                    end
                end
                default: begin
                    state    <= INIT;
                    init_cnt <= '0;
                    rvalid0  <= 1'b0;
                    rvalid1  <= 1'b0;
                end
            endcase
        end
    end

    // RAM command mux: zero-fill writes in INIT, granted port otherwise, idle read of address 0.
    always_comb begin
        ram_wr_en = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (state == INIT) begin
            ram_wr_en = 1'b1;
            ram_addr  = init_cnt;
        end else if (gnt0) begin
            ram_wr_en = we0;
            ram_addr  = addr0;
            ram_wdata = wdata0;
        end else if (gnt1) begin
            ram_wr_en = we1;
            ram_addr  = addr1;
            ram_wdata = wdata1;
        end
    end

endmodule

// File: tb/tb_ram_rw_arbiter.sv
// Directed bench for ram_rw_arbiter with a behavioural single-port RAM attached.
module tb_ram_rw_arbiter;

    localparam int unsigned AW = 2;
    localparam int unsigned DW = 2;
    localparam int NROWS = 31;

    logic          clk = 1'b0;
    logic          reset;
    logic          clr;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, init_done, ram_wr_en;
    logic [DW-1:0] rdata, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;

    logic [DW-1:0] mem [4];

    int checks = 0;
    int passes = 0;

    typedef struct {
        bit clr;
        bit r0, w0; bit [1:0] a0, d0;
        bit r1, w1; bit [1:0] a1, d1;
        bit g0, g1, we; bit [1:0] ad, wd;
        bit rv0, rv1; bit [1:0] rd;
        bit done;
    } vec_t;

    vec_t tbl [NROWS];

    always #5 clk = ~clk;

    ram_rw_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .init_done (init_done),
        .ram_wr_en (ram_wr_en),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Single-port RAM: registered read, output holds on write cycles.
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_addr] <= ram_wdata;
        else           ram_rdata     <= mem[ram_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic vec_t mk(input int c,
                                input int r0, input int w0, input int a0, input int d0,
                                input int r1, input int w1, input int a1, input int d1,
                                input int g0, input int g1, input int we, input int ad, input int wd,
                                input int rv0, input int rv1, input int rd, input int done);
        vec_t v;
        v.clr = 1'(c);
        v.r0 = 1'(r0); v.w0 = 1'(w0); v.a0 = 2'(a0); v.d0 = 2'(d0);
        v.r1 = 1'(r1); v.w1 = 1'(w1); v.a1 = 2'(a1); v.d1 = 2'(d1);
        v.g0 = 1'(g0); v.g1 = 1'(g1); v.we = 1'(we); v.ad = 2'(ad); v.wd = 2'(wd);
        v.rv0 = 1'(rv0); v.rv1 = 1'(rv1); v.rd = 2'(rd); v.done = 1'(done);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        clr = v.clr;
        req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
        req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
    endtask

    task automatic idle();
        clr = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    endtask

    task automatic check_row(input int i, input vec_t v);
        chk($sformatf("row%0d gnt0", i), int'(gnt0), int'(v.g0));
        chk($sformatf("row%0d gnt1", i), int'(gnt1), int'(v.g1));
        chk($sformatf("row%0d ram_wr_en", i), int'(ram_wr_en), int'(v.we));
        chk($sformatf("row%0d ram_addr", i), int'(ram_addr), int'(v.ad));
        chk($sformatf("row%0d ram_wdata", i), int'(ram_wdata), int'(v.wd));
        chk($sformatf("row%0d rvalid0", i), int'(rvalid0), int'(v.rv0));
        chk($sformatf("row%0d rvalid1", i), int'(rvalid1), int'(v.rv1));
        chk($sformatf("row%0d init_done", i), int'(init_done), int'(v.done));
        if (v.rv0 || v.rv1) chk($sformatf("row%0d rdata", i), int'(rdata), int'(v.rd));
    endtask

    initial begin
        // INIT walk after reset
        for (int i = 0; i < 4; i++) tbl[i] = mk(0, 0,0,0,0, 0,0,0,0, 0,0,1,i,0, 0,0,0,0);
        tbl[4]  = mk(0, 1,1,2,3, 0,0,0,0, 1,0,1,2,3, 0,0,0,1);
        tbl[5]  = mk(0, 0,0,0,0, 1,0,2,0, 0,1,0,2,0, 0,0,0,1);
        tbl[6]  = mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,1,3,1);
        tbl[7]  = mk(0, 0,0,0,0, 1,1,1,1, 0,1,1,1,1, 0,0,0,1);
        tbl[8]  = mk(0, 1,1,3,2, 0,0,0,0, 1,0,1,3,2, 0,0,0,1);
        // contention alternates starting from port 1 (port 0 won last)
        tbl[9]  = mk(0, 1,0,1,0, 1,0,3,0, 0,1,0,3,0, 0,0,0,1);
        tbl[10] = mk(0, 1,0,1,0, 1,0,3,0, 1,0,0,1,0, 0,1,2,1);
        tbl[11] = mk(0, 1,0,1,0, 1,0,3,0, 0,1,0,3,0, 1,0,1,1);
        tbl[12] = mk(0, 1,0,1,0, 1,0,3,0, 1,0,0,1,0, 0,1,2,1);
        tbl[13] = mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 1,0,1,1);
        tbl[14] = mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,0,0,1);
        for (int i = 0; i < 4; i++) tbl[15+i] = mk(0, 1,1,i,3, 0,0,0,0, 1,0,1,i,3, 0,0,0,1);
        // clr with a same-cycle read, clr again during INIT, req1 held throughout
        tbl[19] = mk(1, 1,0,0,0, 0,0,0,0, 1,0,0,0,0, 0,0,0,1);
        tbl[20] = mk(0, 0,0,0,0, 1,0,2,0, 0,0,1,0,0, 1,0,3,0);
        tbl[21] = mk(1, 0,0,0,0, 1,0,2,0, 0,0,1,1,0, 0,0,0,0);
        for (int i = 0; i < 4; i++) tbl[22+i] = mk(0, 0,0,0,0, 1,0,2,0, 0,0,1,i,0, 0,0,0,0);
        tbl[26] = mk(0, 0,0,0,0, 1,0,2,0, 0,1,0,2,0, 0,0,0,1);
        tbl[27] = mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,1,0,1);
        tbl[28] = mk(0, 1,0,3,0, 1,0,0,0, 1,0,0,3,0, 0,0,0,1);
        tbl[29] = mk(0, 0,0,0,0, 1,0,0,0, 0,1,0,0,0, 1,0,0,1);
        tbl[30] = mk(0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0, 0,1,0,1);

        idle();
        reset = 1'b1;
        req0 = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset gnt0", int'(gnt0), 0);
        chk("reset gnt1", int'(gnt1), 0);
        chk("reset rvalid0", int'(rvalid0), 0);
        chk("reset rvalid1", int'(rvalid1), 0);
        chk("reset init_done", int'(init_done), 0);
        chk("reset ram_addr", int'(ram_addr), 0);

        for (int i = 0; i < NROWS; i++) begin
            @(negedge clk);
            reset = 1'b0;
            drive(tbl[i]);
            #1;
            check_row(i, tbl[i]);
        end

        // Reset lands while a granted read is in flight: read lost, last returns to port 1.
        @(negedge clk);
        idle();
        req0 = 1'b1; we0 = 1'b1; addr0 = 2'd1; wdata0 = 2'd2;
        #1 chk("pre-reset write gnt0", int'(gnt0), 1);
        @(negedge clk);
        we0 = 1'b0;
        #1 chk("pre-reset read gnt0", int'(gnt0), 1);
        #2 reset = 1'b1;
        #1;
        chk("reset read rvalid0", int'(rvalid0), 0);
        chk("reset read init_done", int'(init_done), 0);
        chk("reset read ram_addr", int'(ram_addr), 0);
        chk("reset read gnt0", int'(gnt0), 0);
        @(negedge clk);
        #1 chk("reset hold rvalid0", int'(rvalid0), 0);
        @(negedge clk);
        reset = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 2'd1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 2'd2;
        #1;
        chk("reinit ram_addr", int'(ram_addr), 0);
        chk("reinit gnt0", int'(gnt0), 0);
        repeat (3) @(negedge clk);
        #1 chk("reinit last addr", int'(ram_addr), 3);
        @(negedge clk);
        #1;
        chk("post-reset gnt0", int'(gnt0), 1);
        chk("post-reset gnt1", int'(gnt1), 0);
        chk("post-reset init_done", int'(init_done), 1);

        // Reset while a read strobe is high drops it at once.
        @(negedge clk);
        req0 = 1'b0;
        #1;
        chk("seq gnt1", int'(gnt1), 1);
        chk("seq rvalid0", int'(rvalid0), 1);
        chk("seq rdata", int'(rdata), 0);
        @(negedge clk);
        idle();
        #1 chk("seq rvalid1", int'(rvalid1), 1);
        #1 reset = 1'b1;
        #1;
        chk("seq reset rvalid1", int'(rvalid1), 0);
        chk("seq reset init_done", int'(init_done), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/ram_rw_arbiter.md
Name: ram_rw_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of one single-port synchronous RAM: RAM_RW (1-cycle registered read, no read on write cycles).
- After reset, or on a clear request, it walks every address and writes zero. Only then does it grant requests.
- It shares the RAM between requester 0 and requester 1 and returns read data with a registered valid strobe.

Parameters:
- ADDR_WIDTH, 2, RAM address width; DEPTH = 1<<ADDR_WIDTH.
- DATA_WIDTH, 2, RAM data width.

Ports:
- clk  in  1  single clock, all state on posedge.
- reset  in  1  asynchronous, active-high reset.
- clr  in  1  pulse: re-zero the whole RAM.
- req0 / req1  in  1  access request from requester 0 / 1; held until granted.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  ADDR_WIDTH  access address.
- wdata0 / wdata1  in  DATA_WIDTH  write data.
- gnt0 / gnt1  out  1  access issued to RAM this cycle (combinational).
- rvalid0 / rvalid1  out  1  read data valid for requester 0 / 1 (registered).
- rdata  out  DATA_WIDTH  read data; wired to ram_rdata; meaningful only while an rvalid is high.
- init_done  out  1  high when in ARB state.
- ram_wr_en  out  1  to RAM wr_en.
- ram_addr  out  ADDR_WIDTH  to RAM addr.
- ram_wdata  out  DATA_WIDTH  to RAM wdata.
- ram_rdata  in  DATA_WIDTH  from RAM rdata.

Behaviour:
- States: INIT, ARB. State register and all counters use async reset.
- Reset values:
  - state = INIT, init_cnt = 0, last = 1 (port 0 wins the first conflict).
  - rvalid0 = rvalid1 = 0; gnt0 = gnt1 = 0.
  - init_done = 0.
- INIT:
  - Drive ram_wr_en = 1, ram_addr = init_cnt, ram_wdata = 0; init_cnt increments each cycle.
  - At init_cnt = DEPTH-1: write the last address, go to ARB next cycle, clear init_cnt.
  - INIT takes exactly DEPTH cycles. No grants; requests are ignored and must stay held.
- ARB, grant logic:
  - Only req0: gnt0. Only req1: gnt1.
  - Both: grant the port not equal to `last`. `last` updates to the granted port on every grant.
  - No req: ram_wr_en = 0, ram_addr = 0, no grant. A harmless read occurs.
  - The granted port's we/addr/wdata are muxed to ram_wr_en/ram_addr/ram_wdata in the same cycle.
- Read latency:
  - A read granted in cycle N gives rvalidX = 1 in cycle N+1 for exactly one cycle.
  - rdata = ram_rdata in that cycle, i.e. the contents at cycle N including any earlier-cycle write.
- Writes produce no rvalid. Back-to-back grants are allowed every cycle.
- clr:
  - Sampled in ARB: next state INIT with init_cnt = 0; the same-cycle grant still completes.
  - clr during INIT restarts the count at 0.
- Reset asserted mid-INIT or mid-read: immediate return to INIT, rvalids drop, the pending read is lost.
- rvalid0 and rvalid1 are never high together.

Decomposition:
- Package ram_arb_pkg: state_t enum {INIT, ARB}; port index typedef (1 bit).
- One sub-module, rr_arb2: 2-request round-robin grant with `last` register.
- Address/data mux, init counter and rvalid pipeline live in the top.

Test Plan:
- Reset release, then idle → ram_wr_en = 1 with ram_addr 0,1,2,3 and wdata 0 for 4 cycles; init_done rises in cycle 5; no gnt during INIT.
- After init: req0 write addr 2 data 3, then req1 read addr 2 → gnt1, next cycle rvalid1 = 1 and rdata = 3; rvalid0 stays 0.
- req0 and req1 both held reading addr 1 and addr 3 → gnt0, then gnt1 on consecutive cycles; rvalid0 then rvalid1 one cycle later each; three-way contention repeated alternates.
- req1 held during INIT → gnt1 only in the first ARB cycle; a read of any address after init returns 0.
- Write 3 to all addresses, pulse clr together with a req0 read of addr 0 → that read returns 3; 4 INIT cycles follow; subsequent reads return 0.
- Assert reset the cycle after a granted read → rvalid stays 0, state INIT, init_cnt 0, last = 1.
